// File: rtl/pattern_scan_ctrl.sv
// pattern_scan_ctrl: accepts a parallel word plus detector configuration,
// scans the word MSB-first through a bit-history pattern detector one bit
// per clock, then presents the hit count and the index of the first hit.
// Optional feature macro: PATTERN_SCAN_MATCH_OUT_EN adds a registered
// match_pulse output that is high for one cycle after each matching shift.
module pattern_scan_ctrl #(
  parameter int DATA_W = 16,
  parameter int PAT_W  = 4,
  parameter int CNT_W  = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [PAT_W-1:0]  cfg_pattern,
  input  logic [3:0]        cfg_len,
  input  logic              cfg_overlap,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [CNT_W-1:0]  res_count,
  output logic [CNT_W-1:0]  res_first,
  output logic              res_hit,
`ifdef PATTERN_SCAN_MATCH_OUT_EN
  output logic              match_pulse,
`endif
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [3:0]       LEN_MAX  = 4'(PAT_W);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(DATA_W - 1);

  state_t             state_q, state_d;
  logic [DATA_W-1:0]  data_q, data_d;      // word, shifted left so the next bit is always the MSB
  logic [PAT_W-1:0]   pat_q, pat_d;
  logic [3:0]         len_q, len_d;        // already clamped to 1..PAT_W
  logic               ovl_q, ovl_d;
  logic [PAT_W-1:0]   hist_q, hist_d;      // bit 0 = most recent bit
  logic [3:0]         fill_q, fill_d;      // valid bits in history, saturates at PAT_W
  logic [CNT_W-1:0]   idx_q, idx_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [CNT_W-1:0]   first_q, first_d;

  logic [PAT_W-1:0]   len_mask;
  logic [PAT_W-1:0]   hist_shift;
  logic [3:0]         fill_inc;
  logic               match;
  logic [3:0]         len_clamped;

  // Mask selecting the low len_q bits of history/pattern for comparison.
  genvar gi;
  generate
    for (gi = 0; gi < PAT_W; gi++) begin : g_mask
      assign len_mask[gi] = (4'(gi) < len_q);
    end
  endgenerate

  assign hist_shift  = {hist_q[PAT_W-2:0], data_q[DATA_W-1]};
  assign fill_inc    = (fill_q == LEN_MAX) ? fill_q : fill_q + 4'd1;
  assign match       = (fill_inc >= len_q) && (((hist_shift ^ pat_q) & len_mask) == '0);
  assign len_clamped = ((cfg_len == 4'd0) || (cfg_len > LEN_MAX)) ? LEN_MAX : cfg_len;

  // Next-state and datapath update for the accept / shift / deliver sequence.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    pat_d   = pat_q;
    len_d   = len_q;
    ovl_d   = ovl_q;
    hist_d  = hist_q;
    fill_d  = fill_q;
    idx_d   = idx_q;
    count_d = count_q;
    first_d = first_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          data_d  = in_data;
          pat_d   = cfg_pattern;
          len_d   = len_clamped;
          ovl_d   = cfg_overlap;
          fill_d  = 4'd0;
          idx_d   = '0;
          count_d = '0;
          first_d = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        data_d = data_q << 1;
        hist_d = hist_shift;
        fill_d = fill_inc;
        idx_d  = idx_q + CNT_W'(1);
        if (match) begin
          count_d = count_q + CNT_W'(1);
          if (count_q == '0) first_d = idx_q;
          if (!ovl_q) fill_d = 4'd0;
        end
        if (idx_q == LAST_IDX) state_d = DONE;
      end
      DONE: begin
        if (res_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      data_q  <= '0;
      pat_q   <= '0;
      len_q   <= LEN_MAX;
      ovl_q   <= 1'b0;
      hist_q  <= '0;
      fill_q  <= 4'd0;
      idx_q   <= '0;
      count_q <= '0;
      first_q <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      pat_q   <= pat_d;
      len_q   <= len_d;
      ovl_q   <= ovl_d;
      hist_q  <= hist_d;
      fill_q  <= fill_d;
      idx_q   <= idx_d;
      count_q <= count_d;
      first_q <= first_d;
    end
  end

`ifdef PATTERN_SCAN_MATCH_OUT_EN
  logic match_q;

  // One-cycle pulse following every shift edge that found a match.
  always_ff @(posedge clk) begin
    if (!reset) match_q <= 1'b0;
    else        match_q <= (state_q == SHIFT) && match;
  end

  assign match_pulse = match_q;
`endif

  assign in_ready  = (state_q == IDLE);
  assign res_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign res_count = count_q;
  assign res_first = first_q;
  assign res_hit   = (count_q != '0);

endmodule

// File: tb/tb_pattern_scan_ctrl.sv
// Bench for pattern_scan_ctrl: directed words with hand-computed results
// plus randomized words, all checked every cycle against a window-scan model.
module tb_pattern_scan_ctrl;
  localparam int DATA_W = 16;
  localparam int PAT_W  = 4;
  localparam int CNT_W  = 5;

  logic              clk = 1'b0;
  logic              reset;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [PAT_W-1:0]  cfg_pattern;
  logic [3:0]        cfg_len;
  logic              cfg_overlap;
  logic              res_valid;
  logic              res_ready;
  logic [CNT_W-1:0]  res_count;
  logic [CNT_W-1:0]  res_first;
  logic              res_hit;
  logic              busy;
`ifdef PATTERN_SCAN_MATCH_OUT_EN
  logic              match_pulse;
`endif

  int tests  = 0;
  int failed = 0;

  always #5 clk = ~clk;

  pattern_scan_ctrl #(.DATA_W(DATA_W), .PAT_W(PAT_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_overlap(cfg_overlap),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_count(res_count), .res_first(res_first), .res_hit(res_hit),
`ifdef PATTERN_SCAN_MATCH_OUT_EN
    .match_pulse(match_pulse),
`endif
    .busy(busy)
  );

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      failed++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: slide a window over the bit sequence; a match needs len bits
  // since the last restart point and equal to the pattern (earliest bit first).
  function automatic void ref_scan(input logic [DATA_W-1:0] d, input logic [PAT_W-1:0] p,
                                   input int len_in, input bit ovl,
                                   output int cnt, output int first,
                                   output logic [DATA_W-1:0] mask);
    int len;
    int start;
    bit ok;
    len = (len_in == 0 || len_in > PAT_W) ? PAT_W : len_in;
    cnt = 0; first = 0; mask = '0; start = 0;
    for (int i = 0; i < DATA_W; i++) begin
      ok = (i - len + 1 >= start);
      if (ok) begin
        for (int j = 0; j < len; j++)
          if (d[DATA_W-1-(i-len+1+j)] != p[len-1-j]) ok = 0;
      end
      if (ok) begin
        cnt++;
        if (cnt == 1) first = i;
        mask[i] = 1'b1;
        if (!ovl) start = i + 1;
      end
    end
  endfunction

  // Model state, advanced at each falling edge from the inputs the next
  // rising edge will see.
  int               m_phase = 0;   // 0 idle, 1 scanning, 2 result held
  int               m_k = 0;
  bit               m_known = 0;
  bit               m_after_reset = 0;
  int               e_count = 0;
  int               e_first = 0;
  logic [DATA_W-1:0] e_mask = '0;
  bit               e_pulse = 0;

  always @(negedge clk) begin
    if (m_known) begin
      chk("in_ready", int'(in_ready), int'(m_phase == 0));
      chk("busy", int'(busy), int'(m_phase != 0));
      chk("res_valid", int'(res_valid), int'(m_phase == 2));
      if (m_phase == 2 || m_after_reset) begin
        chk("res_count", int'(res_count), e_count);
        chk("res_first", int'(res_first), e_first);
        chk("res_hit", int'(res_hit), int'(e_count != 0));
      end
`ifdef PATTERN_SCAN_MATCH_OUT_EN
      chk("match_pulse", int'(match_pulse), int'(e_pulse));
`endif
    end
    e_pulse = 0;
    if (!reset) begin
      m_phase = 0; m_known = 1; m_after_reset = 1;
      e_count = 0; e_first = 0;
    end else if (m_known) begin
      case (m_phase)
        0: if (in_valid) begin
          ref_scan(in_data, cfg_pattern, int'(cfg_len), cfg_overlap, e_count, e_first, e_mask);
          m_after_reset = 0;
          m_phase = 1; m_k = 0;
        end
        1: begin
          e_pulse = e_mask[m_k];
          m_k++;
          if (m_k == DATA_W) m_phase = 2;
        end
        default: if (res_ready) m_phase = 0;
      endcase
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Offer one word, wait for its result, hold it for 'hold' cycles while
  // scribbling on the input side, then take it.
  task automatic run_word(input logic [DATA_W-1:0] d, input logic [PAT_W-1:0] p,
                          input logic [3:0] l, input bit o, input int hold,
                          output int c, output int f, output int h);
    int n;
    n = 0;
    while (!in_ready && n < 50) begin cyc(); n++; end
    if (!in_ready) chk("in_ready_timeout", 0, 1);
    in_valid = 1'b1; in_data = d; cfg_pattern = p; cfg_len = l; cfg_overlap = o;
    cyc();
    in_valid = 1'b0;
    in_data = DATA_W'($urandom); cfg_pattern = PAT_W'($urandom);
    cfg_len = 4'($urandom); cfg_overlap = 1'($urandom);
    n = 0;
    while (!res_valid && n < 3 * DATA_W) begin cyc(); n++; end
    if (!res_valid) chk("res_valid_timeout", 0, 1);
    c = int'(res_count); f = int'(res_first); h = int'(res_hit);
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'($urandom); in_data = DATA_W'($urandom);
      cfg_pattern = PAT_W'($urandom); cfg_len = 4'($urandom);
      cyc();
    end
    in_valid = 1'b0;
    res_ready = 1'b1;
    cyc();
    res_ready = 1'b0;
  endtask

  initial begin
    int c, f, h;
    reset = 1'b0; in_valid = 1'b0; in_data = '0; cfg_pattern = '0;
    cfg_len = 4'd0; cfg_overlap = 1'b0; res_ready = 1'b0;
    repeat (3) cyc();
    reset = 1'b1;
    cyc();

    run_word(16'h9249, 4'b1001, 4'd4, 1'b1, 0, c, f, h);
    $display("[TB] word 9249 pat 1001 len 4 ovl 1 -> count %0d first %0d hit %0d", c, f, h);
    chk("lit_ovl_count", c, 5); chk("lit_ovl_first", f, 3); chk("lit_ovl_hit", h, 1);

    run_word(16'h9249, 4'b1001, 4'd4, 1'b0, 0, c, f, h);
    $display("[TB] word 9249 pat 1001 len 4 ovl 0 -> count %0d first %0d", c, f);
    chk("lit_novl_count", c, 3); chk("lit_novl_first", f, 3);

    run_word(16'hAAAA, 4'b0101, 4'd3, 1'b1, 0, c, f, h);
    $display("[TB] word AAAA pat 101 len 3 -> count %0d first %0d", c, f);
    chk("lit_len3_count", c, 7); chk("lit_len3_first", f, 2);

    run_word(16'h0000, 4'b0000, 4'd0, 1'b1, 0, c, f, h);
    $display("[TB] word 0000 pat 0000 len 0 -> count %0d first %0d", c, f);
    chk("lit_clamp_count", c, 13); chk("lit_clamp_first", f, 3);

    run_word(16'hFFFF, 4'b1001, 4'd4, 1'b1, 5, c, f, h);
    $display("[TB] word FFFF pat 1001 held 5 -> count %0d first %0d hit %0d", c, f, h);
    chk("lit_none_count", c, 0); chk("lit_none_first", f, 0); chk("lit_none_hit", h, 0);

    // Abort a scan with reset at bit index 7, then rescan cleanly.
    in_valid = 1'b1; in_data = 16'hFFFF; cfg_pattern = 4'b1111; cfg_len = 4'd4; cfg_overlap = 1'b1;
    cyc();
    in_valid = 1'b0;
    repeat (7) cyc();
    reset = 1'b0;
    cyc();
    reset = 1'b1;
    $display("[TB] reset mid-scan -> in_ready %0d res_valid %0d count %0d", in_ready, res_valid, res_count);
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_res_valid", int'(res_valid), 0);
    chk("rst_count", int'(res_count), 0);
    run_word(16'h9249, 4'b1001, 4'd4, 1'b1, 1, c, f, h);
    $display("[TB] after reset word 9249 -> count %0d first %0d", c, f);
    chk("post_rst_count", c, 5); chk("post_rst_first", f, 3);

    for (int t = 0; t < 40; t++) begin
      logic [DATA_W-1:0] d;
      logic [PAT_W-1:0]  p;
      logic [3:0]        l;
      bit                o;
      d = DATA_W'($urandom);
      if (t % 4 == 0) d = {DATA_W/2{2'($urandom)}};
      p = PAT_W'($urandom);
      l = 4'($urandom_range(0, 15));
      o = 1'($urandom);
      repeat ($urandom_range(0, 2)) cyc();
      run_word(d, p, l, o, $urandom_range(0, 3), c, f, h);
      $display("[TB] rand word %h pat %b len %0d ovl %0d -> count %0d first %0d", d, p, l, o, c, f);
    end

    repeat (3) cyc();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule

// File: doc/pattern_scan_ctrl.md
Name: pattern_scan_ctrl

Overview:
- Controller that sequences a serial pattern-detection datapath over parallel input words.
- Accepts a DATA_W-bit word through a valid/ready handshake and latches the detector configuration: pattern, length and overlap mode.
- Feeds the word MSB-first, one bit per clock, through an internal Moore-style bit-history detector, then returns the hit count and first-hit index through a second valid/ready handshake.
- Sits between a word-oriented producer and consumer, replacing hand-driven serial stimulus of the detector.

Parameters:
DATA_W, 16, bits per input word (>=2)
PAT_W, 4, maximum pattern length in bits (2..8)
CNT_W, 5, width of count/index outputs; must satisfy 2**CNT_W > DATA_W

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-low reset
in_valid  input  1  word available
in_ready  output  1  controller can accept a word
in_data  input  DATA_W  word to scan, MSB sent first
cfg_pattern  input  PAT_W  pattern; bit cfg_len-1 is the earliest bit, bit 0 the latest
cfg_len  input  4  pattern length; 0 or >PAT_W clamps to PAT_W
cfg_overlap  input  1  1 = overlapping matches counted, 0 = history cleared after each match
res_valid  output  1  result available
res_ready  input  1  consumer takes result
res_count  output  CNT_W  number of matches in the word
res_first  output  CNT_W  bit index (0 = MSB) of the last bit of the first match; 0 if none
res_hit  output  1  res_count != 0
busy  output  1  state != IDLE

Behaviour:
- Reset (reset==0 at a rising edge): state=IDLE, in_ready=1, res_valid=0, res_count=0, res_first=0, res_hit=0, busy=0; history, fill counter and bit index cleared. Reset overrides all other activity, including mid-SHIFT or mid-DONE; the in-flight word is discarded.
- States:
  - IDLE: in_ready=1. On in_valid&in_ready, capture in_data, cfg_pattern, clamped cfg_len and cfg_overlap into shadow registers; clear count, first, fill and index; go to SHIFT.
  - SHIFT: each edge shifts the bit in_data[DATA_W-1-idx] into the LSB of a PAT_W-bit history and increments fill (saturating at PAT_W).
    - Match condition: fill_after_shift >= len and history_after_shift[len-1:0] == pattern[len-1:0].
    - On match: count+1; if this is the first match, first=idx. If overlap=0, fill clears to 0 in the same edge.
    - After the edge with idx==DATA_W-1, go to DONE.
  - DONE: res_valid=1 with res_count, res_first and res_hit stable. On res_ready, go to IDLE and drop res_valid at that edge.
- in_ready=0 and in_valid are ignored outside IDLE. Cfg inputs are ignored outside the accept edge.
- Latency: res_valid is high starting DATA_W edges after the accept edge. Minimum word period is DATA_W+2 cycles.
- Count never exceeds DATA_W, so no saturation logic is required.

Optional Feature:
- Macro PATTERN_SCAN_MATCH_OUT_EN.
- Defined: adds output port match_pulse (1 bit, registered, reset 0). It is high for exactly one cycle following each SHIFT edge that detected a match, and low otherwise.
- Undefined: the port and its register are absent; all other behaviour is identical.

Test Plan:
- PAT=4'b1001, len=4, overlap=1, data=16'h9249 -> res_valid 16 edges after accept; count=5, first=3, hit=1.
- Same word with overlap=0 -> count=3, first=3 (matches at idx 3, 9, 15).
- PAT=4'b0101, len=3, overlap=1, data=16'hAAAA -> count=7, first=2; len=0, PAT=4'b0000, data=16'h0000 -> len clamps to 4, count=13, first=3.
- PAT=4'b1001, data=16'hFFFF -> count=0, first=0, hit=0.
- Hold res_ready=0 for 5 cycles in DONE while pulsing in_valid and changing cfg -> res_valid and outputs stable, in_ready=0, no capture; res_ready=1 -> IDLE next edge, then in_ready=1.
- Assert reset low for one edge at idx 7 of SHIFT -> next cycle state IDLE, in_ready=1, res_valid=0, count=0; a following word scans correctly from a clean history.
